// File: rtl/inst_fetch.sv
// Instruction fetch unit: requests one word at a time from instruction memory,
// holds it for the decode stage and computes the next pc from decoded control flags.
//
// Ports:
//   clk, rst_n               clock and asynchronous active-low reset
//   imem_req, imem_addr      read request and byte address (= pc)
//   imem_ack, imem_rdata     read-data strobe and instruction word
//   inst, opcode, pc_out     held instruction, its opcode field and its address
//   inst_valid               held instruction is valid
//   inst_ready, stall        downstream consume handshake; stall blocks consumption
//   branch_eq, branch_neq,
//   jump, zero               control flags for the held instruction
//   fetch_err                sticky memory-timeout flag
module inst_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [5:0]  opcode,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        stall,
    input  logic        branch_eq,
    input  logic        branch_neq,
    input  logic        jump,
    input  logic        zero,
    output logic [63:0] pc_out,
    output logic        fetch_err
);

    localparam int unsigned PC_W   = 64;
    localparam int unsigned INST_W = 32;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PC_W-1:0]     pc;
    logic [PC_W-1:0]     pc4;
    logic [PC_W-1:0]     imm;
    logic [PC_W-1:0]     next_pc;
    logic [CNT_W-1:0]    wait_cnt;
    logic                take_branch;
    logic                consume;
    logic                capture;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; an ack on the timeout edge still wins
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    state_nxt = HOLD;
                end else if (wait_cnt == TIMEOUT) begin
                    state_nxt = ERR;
                end
            end
            HOLD:  begin
                if (inst_ready && !stall) begin
                    state_nxt = FETCH;
                end
            end
            ERR:   state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs decoded from the state register
    always_comb begin
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        fetch_err  = 1'b0;
        case (state)
            FETCH:   imem_req   = 1'b1;
            HOLD:    inst_valid = 1'b1;
            ERR:     fetch_err  = 1'b1;
            default: ;
        endcase
    end

    assign capture = (state == FETCH) && imem_ack;
    assign consume = (state == HOLD) && inst_ready && !stall;

    // Next pc: jump beats branches; beq and bne together act as an unconditional branch
    always_comb begin
        pc4         = pc + PC_W'(4);
        imm         = {{(PC_W-18){inst[15]}}, inst[15:0], 2'b00};
        take_branch = (branch_eq && zero) || (branch_neq && !zero);
        if (jump) begin
            next_pc = {pc4[63:28], inst[25:0], 2'b00};
        end else if (take_branch) begin
            next_pc = pc4 + imm;
        end else begin
            next_pc = pc4;
        end
    end

    // Datapath registers; pc is kept word aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= {RESET_PC[63:2], 2'b00};
            inst   <= '0;
            pc_out <= '0;
        end else begin
            if (capture) begin
                inst   <= imem_rdata;
                pc_out <= pc;
            end
            if (consume) begin
                pc <= next_pc;
            end
        end
    end

    // Wait counter: cleared on FETCH entry, counts FETCH cycles without ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if ((state != FETCH) && (state_nxt == FETCH)) begin
            wait_cnt <= '0;
        end else if ((state == FETCH) && !imem_ack) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign imem_addr = pc;
    assign opcode    = inst[INST_W-1:INST_W-6];

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: RESET_PC, default 64'h0, sets the first fetch address after reset.
REQ-002 Parameter: TIMEOUT, default 8'd255, sets the FETCH cycles allowed without imem_ack before error.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  64  byte address of the request; equals pc.
REQ-007 imem_ack  input  1  read-data-valid strobe from instruction memory.
REQ-008 imem_rdata  input  32  instruction word; valid when imem_ack=1.
REQ-009 inst  output  32  held instruction word.
REQ-010 opcode  output  6  inst[31:26]; feeds the decode control unit.
REQ-011 inst_valid  output  1  inst, opcode and pc_out are valid.
REQ-012 inst_ready  input  1  downstream consumes the held instruction.
REQ-013 stall  input  1  blocks consumption while high.
REQ-014 branch_eq, branch_neq, jump  input  1 each  decoded control flags for the held instruction.
REQ-015 zero  input  1  ALU zero flag for the held instruction.
REQ-016 pc_out  output  64  address of the held instruction.
REQ-017 fetch_err  output  1  sticky memory-timeout flag.

Function
REQ-018 The FSM states SHALL be IDLE, FETCH, HOLD and ERR.
REQ-019 IDLE SHALL go to FETCH on the first clk edge after reset release; imem_req=0 in IDLE.
REQ-020 FETCH: imem_req=1 and imem_addr=pc; on an edge with imem_ack=1, inst<=imem_rdata, pc_out<=pc, go to HOLD.
REQ-021 HOLD: inst_valid=1 and imem_req=0; on an edge with inst_ready=1 and stall=0, pc<=next_pc and go to FETCH.
REQ-022 inst_valid SHALL drop the cycle after consumption and rise the cycle after a captured ack, so minimum throughput is one instruction per 2 cycles plus memory latency.
REQ-023 pc4 = pc+4. Define imm = sign-extended inst[15:0], shifted left by 2, 64 bits.
REQ-024 next_pc SHALL be:
- if jump=1: {pc4[63:28], inst[25:0], 2'b00};
- else if (branch_eq & zero) | (branch_neq & ~zero): pc4+imm;
- else pc4.
REQ-025 jump SHALL take priority over branches; branch_eq=branch_neq=1 SHALL act as an unconditional branch.
REQ-026 All pc arithmetic SHALL be modulo 2^64; pc[1:0] SHALL always be 2'b00.
REQ-027 stall and inst_ready SHALL be ignored outside HOLD; imem_ack SHALL be ignored outside FETCH.
REQ-028 An 8-bit wait counter SHALL clear on FETCH entry and increment on each FETCH cycle without ack.
REQ-029 When the counter equals TIMEOUT with imem_ack=0, the FSM SHALL go to ERR; an ack on that same edge wins and goes to HOLD.
REQ-030 ERR: fetch_err=1, imem_req=0, inst_valid=0; ERR SHALL be left only via reset.
REQ-031 opcode SHALL always equal inst[31:26].

Reset
REQ-032 While rst_n=0, all outputs and state SHALL be forced immediately, without a clock: state=IDLE, pc=RESET_PC, inst=0, pc_out=0, counter=0, imem_req=0, inst_valid=0, fetch_err=0.
REQ-033 Reset asserted mid-FETCH SHALL drop imem_req at once; a late ack arriving in IDLE SHALL be discarded.

Verification
REQ-034 Reset release, memory acks after 2 cycles with 32'h20080005 -> imem_addr=0, inst_valid high with opcode=6'b001000; consumption -> next imem_addr=4.
REQ-035 Held inst=32'h1000FFFF at pc=0x100, branch_eq=1, zero=1, consume -> next imem_addr=0x100; same with zero=0 -> 0x104.
REQ-036 Held inst=32'h08000040 at pc=0x1000, jump=1, branch_neq=1, zero=0 -> next imem_addr=0x100 (jump wins).
REQ-037 HOLD with inst_ready=1 and stall=1 for 3 cycles -> pc and inst unchanged and inst_valid stays high; stall=0 -> advance on that edge.
REQ-038 TIMEOUT=4, no ack -> ERR after 5 FETCH cycles with fetch_err=1; ack on the 5th cycle -> HOLD instead; rst_n pulse -> fetch_err=0 and fetch restarts at RESET_PC.
